// File: rtl/cpc_bus_pkg.sv
//------------------------------------------------------------------------------
// Module      : cpc_bus_pkg
// Description : Shared encodings and constants for the CPC Z80 bus master.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package cpc_bus_pkg;

  typedef enum logic [1:0] {
    CMD_MEM_RD = 2'b00,
    CMD_MEM_WR = 2'b01,
    CMD_IO_WR  = 2'b10,
    CMD_RSVD   = 2'b11
  } cmd_type_e;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_T1   = 3'd1,
    ST_T2   = 3'd2,
    ST_TW   = 3'd3,
    ST_T3   = 3'd4
  } state_e;

  // Gate-array bank select: I/O write with A15 low and data tag 11 in bits 7:6
  localparam logic       BANK_ADR15   = 1'b0;
  localparam logic [1:0] BANK_SEL_TAG = 2'b11;

  localparam logic [7:0] WAIT_LIMIT = 8'd255;

  function automatic logic is_bank_select(input logic adr15, input logic [7:0] data);
    return (adr15 == BANK_ADR15) && (data[7:6] == BANK_SEL_TAG);
  endfunction

endpackage

`default_nettype wire

// File: rtl/cpc_wait_timer.sv
//------------------------------------------------------------------------------
// Module      : cpc_wait_timer
// Description : Counts wait states of one bus cycle and flags the abort point.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cpc_wait_timer
  import cpc_bus_pkg::*;
(
  input  logic clk,
  input  logic reset_b,
  input  logic clear,
  input  logic inc,
  output logic abort
);

  logic [7:0] r_count;

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_count <= 8'd0;
    end else if (clear) begin
      r_count <= 8'd0;
    end else if (inc && (r_count != WAIT_LIMIT)) begin
      r_count <= r_count + 8'd1;
    end
  end

  // Fires in the TW cycle whose increment brings the count to the limit
  assign abort = inc && (r_count == (WAIT_LIMIT - 8'd1));

endmodule

`default_nettype wire

// File: rtl/cpc_bus_master.sv
//------------------------------------------------------------------------------
// Module      : cpc_bus_master
// Description : Command-driven Z80 T-state bus master (mem read/write, I/O
//               write) with wait/abort handling and bank-select shadow.
//               Define CPC_IO_AUTOWAIT_EN for the automatic I/O wait state.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module cpc_bus_master
  import cpc_bus_pkg::*;
(
  input  logic        clk,
  input  logic        reset_b,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_type,
  input  logic [15:0] cmd_addr,
  input  logic [7:0]  cmd_data,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        rsp_err,
  output logic [15:0] adr,
  output logic [7:0]  dout,
  output logic        dout_oe,
  input  logic [7:0]  din,
  output logic        mreq_b,
  output logic        iorq_b,
  output logic        rd_b,
  output logic        wr_b,
  output logic        ramrd_b,
  input  logic        wait_b,
  output logic [5:0]  bank_shadow
);

  state_e    r_state;
  cmd_type_e r_type;
  cmd_type_e w_cmd_type;
  logic      w_accept;
  logic      w_tmr_clear;
  logic      w_tmr_inc;
  logic      w_tmr_abort;
  logic      w_bank_hit;
  logic      w_force_tw;

  assign w_cmd_type  = cmd_type_e'(cmd_type);
  assign w_accept    = cmd_valid & cmd_ready;
  assign w_tmr_clear = (r_state == ST_T1);
  assign w_tmr_inc   = (r_state == ST_TW);
  assign w_bank_hit  = (r_type == CMD_IO_WR) && is_bank_select(adr[15], dout);

`ifdef CPC_IO_AUTOWAIT_EN
  assign w_force_tw = (r_type == CMD_IO_WR);
`else
  assign w_force_tw = 1'b0;
`endif

  cpc_wait_timer u_wait_timer (
    .clk     (clk),
    .reset_b (reset_b),
    .clear   (w_tmr_clear),
    .inc     (w_tmr_inc),
    .abort   (w_tmr_abort)
  );

  always_ff @(posedge clk or negedge reset_b) begin
    if (!reset_b) begin
      r_state     <= ST_IDLE;
      r_type      <= CMD_MEM_RD;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_data    <= 8'd0;
      rsp_err     <= 1'b0;
      adr         <= 16'd0;
      dout        <= 8'd0;
      dout_oe     <= 1'b0;
      mreq_b      <= 1'b1;
      iorq_b      <= 1'b1;
      rd_b        <= 1'b1;
      wr_b        <= 1'b1;
      ramrd_b     <= 1'b1;
      bank_shadow <= 6'd0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (w_accept) begin
            if (w_cmd_type == CMD_RSVD) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
            end else begin
              r_state   <= ST_T1;
              cmd_ready <= 1'b0;
              r_type    <= w_cmd_type;
              adr       <= cmd_addr;
              if (w_cmd_type != CMD_MEM_RD) begin
                dout    <= cmd_data;
                dout_oe <= 1'b1;
              end
            end
          end
        end

        ST_T1: begin
          r_state <= ST_T2;
          mreq_b  <= (r_type == CMD_IO_WR);
          iorq_b  <= (r_type != CMD_IO_WR);
          rd_b    <= (r_type != CMD_MEM_RD);
          ramrd_b <= (r_type != CMD_MEM_RD);
          wr_b    <= (r_type != CMD_IO_WR);
        end

        ST_T2: begin
          r_state <= (w_force_tw || !wait_b) ? ST_TW : ST_T3;
          // Memory writes assert wr_b one T-state later than I/O writes
          if (r_type != CMD_MEM_RD) begin
            wr_b <= 1'b0;
          end
        end

        ST_TW: begin
          if (w_tmr_abort) begin
            r_state   <= ST_IDLE;
            cmd_ready <= 1'b1;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            dout_oe   <= 1'b0;
            mreq_b    <= 1'b1;
            iorq_b    <= 1'b1;
            rd_b      <= 1'b1;
            wr_b      <= 1'b1;
            ramrd_b   <= 1'b1;
          end else if (wait_b) begin
            r_state <= ST_T3;
          end
        end

        ST_T3: begin
          r_state   <= ST_IDLE;
          cmd_ready <= 1'b1;
          dout_oe   <= 1'b0;
          mreq_b    <= 1'b1;
          iorq_b    <= 1'b1;
          rd_b      <= 1'b1;
          wr_b      <= 1'b1;
          ramrd_b   <= 1'b1;
          if (r_type == CMD_MEM_RD) begin
            rsp_valid <= 1'b1;
            rsp_data  <= din;
          end
          if (w_bank_hit) begin
            bank_shadow <= dout[5:0];
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_cpc_bus_master.sv
//------------------------------------------------------------------------------
// Module      : tb_cpc_bus_master
// Description : Randomized scoreboard bench for cpc_bus_master.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_cpc_bus_master;

`ifdef CPC_IO_AUTOWAIT_EN
  localparam int AUTO_TW = 1;
`else
  localparam int AUTO_TW = 0;
`endif

  localparam logic [1:0] T_MRD = 2'b00;
  localparam logic [1:0] T_MWR = 2'b01;
  localparam logic [1:0] T_IOW = 2'b10;
  localparam logic [1:0] T_RSV = 2'b11;

  logic        clk = 1'b0;
  logic        reset_b;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_type;
  logic [15:0] cmd_addr;
  logic [7:0]  cmd_data;
  logic        rsp_valid;
  logic [7:0]  rsp_data;
  logic        rsp_err;
  logic [15:0] adr;
  logic [7:0]  dout;
  logic        dout_oe;
  logic [7:0]  din;
  logic        mreq_b, iorq_b, rd_b, wr_b, ramrd_b;
  logic        wait_b;
  logic [5:0]  bank_shadow;

  cpc_bus_master dut (
    .clk(clk), .reset_b(reset_b),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .adr(adr), .dout(dout), .dout_oe(dout_oe), .din(din),
    .mreq_b(mreq_b), .iorq_b(iorq_b), .rd_b(rd_b), .wr_b(wr_b), .ramrd_b(ramrd_b),
    .wait_b(wait_b), .bank_shadow(bank_shadow)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int passes = 0;

  task automatic check(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  typedef struct {
    logic [7:0] data;
    bit         err;
    int         at;
  } rsp_t;

  rsp_t       exp_q[$];
  logic [5:0] exp_shadow = 6'd0;

  // Scoreboard monitor: every response the DUT presents is matched in order
  always @(negedge clk) begin
    if (reset_b === 1'b1 && rsp_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        check(1'b0, "rsp_unexpected", 1, 0);
      end else begin
        rsp_t e;
        e = exp_q.pop_front();
        check(rsp_err == e.err, "rsp_err", int'(rsp_err), int'(e.err));
        check(cyc == e.at, "rsp_cycle", cyc, e.at);
        if (!e.err) check(rsp_data == e.data, "rsp_data", int'(rsp_data), int'(e.data));
      end
    end
  end

  // Issues one command at the current negedge and follows it to completion.
  task automatic run_cmd(input logic [1:0] t, input logic [15:0] addr,
                         input logic [7:0] data, input int nwait, input logic [7:0] dinv);
    int a, k, tw, t3, lows, guard, bad;
    int e_mreq, e_iorq, e_rd, e_wr, e_ramrd;
    int c_mreq, c_iorq, c_rd, c_wr, c_ramrd;
    bit is_io, is_rd, is_wr, abort;
    logic [4:0]  strb;
    logic [31:0] r;

    guard = 0;
    while (!cmd_ready && guard < 600) begin
      @(negedge clk);
      guard++;
    end
    if (!cmd_ready) begin
      check(1'b0, "ready_timeout", guard, 0);
      return;
    end

    din       = dinv;
    cmd_type  = t;
    cmd_addr  = addr;
    cmd_data  = data;
    cmd_valid = 1'b1;
    a = cyc + 1;

    is_io = (t == T_IOW);
    is_rd = (t == T_MRD);
    is_wr = (t == T_MWR) || is_io;

    if (t == T_RSV) begin
      exp_q.push_back('{data: 8'h00, err: 1'b1, at: a});
      @(negedge clk);
      cmd_valid = 1'b0;
      return;
    end

    // Reference: T1, T2, tw wait states, then T3 unless the wait limit hit
    k     = nwait + (is_io ? AUTO_TW : 0);
    abort = (k >= 255);
    tw    = abort ? 255 : k;
    t3    = abort ? 0 : 1;
    lows  = 1 + tw + t3;
    e_mreq  = is_io ? 0 : lows;
    e_iorq  = is_io ? lows : 0;
    e_rd    = is_rd ? lows : 0;
    e_ramrd = is_rd ? lows : 0;
    e_wr    = is_io ? lows : ((t == T_MWR) ? tw + t3 : 0);
    if (is_rd || abort) exp_q.push_back('{data: dinv, err: abort, at: a + 2 + tw + t3});
    if (is_io && !abort && addr[15] == 1'b0 && data[7:6] == 2'b11) exp_shadow = data[5:0];

    c_mreq = 0; c_iorq = 0; c_rd = 0; c_wr = 0; c_ramrd = 0; bad = 0; guard = 0;
    @(negedge clk);
    while (!cmd_ready && guard < 600) begin
      strb = {mreq_b, iorq_b, rd_b, wr_b, ramrd_b};
      if (!mreq_b)  c_mreq++;
      if (!iorq_b)  c_iorq++;
      if (!rd_b)    c_rd++;
      if (!wr_b)    c_wr++;
      if (!ramrd_b) c_ramrd++;
      if (cyc == a && strb != 5'h1f) bad++;
      if (adr != addr) bad++;
      if (dout_oe != is_wr) bad++;
      if (is_wr && dout != data) bad++;
      // wait_b for the coming edge; sample points start at the end of T2
      wait_b = !((cyc + 1) >= a + 2 && (cyc + 1) < a + 2 + k);
      r = $urandom;
      cmd_valid = r[0];
      cmd_type  = r[2:1];
      cmd_addr  = r[18:3];
      cmd_data  = r[26:19];
      guard++;
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    r = $urandom;
    wait_b = r[0];
    if (!cmd_ready) begin
      check(1'b0, "txn_timeout", guard, 0);
      return;
    end

    strb = {mreq_b, iorq_b, rd_b, wr_b, ramrd_b};
    check(cyc == a + 2 + tw + t3, "txn_end_cycle", cyc, a + 2 + tw + t3);
    check(c_mreq == e_mreq, "mreq_low_cycles", c_mreq, e_mreq);
    check(c_iorq == e_iorq, "iorq_low_cycles", c_iorq, e_iorq);
    check(c_rd == e_rd && c_ramrd == e_ramrd, "rd_ramrd_low_cycles", c_rd * 1000 + c_ramrd, e_rd * 1000 + e_ramrd);
    check(c_wr == e_wr, "wr_low_cycles", c_wr, e_wr);
    check(bad == 0, "bus_drive", bad, 0);
    check(strb == 5'h1f && !dout_oe && adr == addr, "idle_bus", int'({strb, dout_oe}), 'h3e);
    check(bank_shadow == exp_shadow, "bank_shadow", int'(bank_shadow), int'(exp_shadow));
  endtask

  initial begin
    logic [31:0] r1, r2;
    int nw;

    reset_b = 1'b0; cmd_valid = 1'b0; cmd_type = 2'b00; cmd_addr = 16'h0;
    cmd_data = 8'h0; din = 8'h0; wait_b = 1'b1;

    repeat (3) @(negedge clk);
    check(cmd_ready == 1'b0, "reset_cmd_ready", int'(cmd_ready), 0);
    check({mreq_b, iorq_b, rd_b, wr_b, ramrd_b} == 5'h1f, "reset_strobes",
          int'({mreq_b, iorq_b, rd_b, wr_b, ramrd_b}), 'h1f);
    check(adr == 16'h0 && dout == 8'h0 && !dout_oe, "reset_bus", int'(adr), 0);
    check(!rsp_valid && !rsp_err && rsp_data == 8'h0, "reset_rsp", int'({rsp_valid, rsp_err, rsp_data}), 0);
    check(bank_shadow == 6'h0, "reset_shadow", int'(bank_shadow), 0);
    reset_b = 1'b1;
    #1 check(cmd_ready == 1'b0, "ready_before_rise", int'(cmd_ready), 0);
    @(posedge clk);
    #1 check(cmd_ready == 1'b1, "ready_after_rise", int'(cmd_ready), 1);
    @(negedge clk);

    // Directed cases
    run_cmd(T_IOW, 16'h7F00, 8'hC2, 0, 8'h00);
    check(bank_shadow == 6'h02, "shadow_C2", int'(bank_shadow), 'h02);
    run_cmd(T_IOW, 16'h7F00, 8'h7F, 0, 8'h00);
    run_cmd(T_IOW, 16'hFF00, 8'hC5, 0, 8'h00);
    run_cmd(T_MRD, 16'h4000, 8'h00, 0, 8'hA5);
    run_cmd(T_MWR, 16'hC000, 8'h3C, 3, 8'h00);
    run_cmd(T_RSV, 16'h1234, 8'h56, 0, 8'h00);
    run_cmd(T_MRD, 16'h8001, 8'h00, 400, 8'h5A);
    check(bank_shadow == 6'h02, "shadow_after_abort", int'(bank_shadow), 'h02);

    // Randomized traffic
    for (int i = 0; i < 40; i++) begin
      r1 = $urandom;
      r2 = $urandom;
      nw = (r1[31:30] == 2'b00) ? int'($urandom_range(1, 6)) : 0;
      run_cmd(r1[1:0], r2[15:0], r1[20] ? {2'b11, r1[26:21]} : r2[23:16], nw, r2[31:24]);
    end

    // Reset pulsed during TW of a bank-select I/O write
    while (!cmd_ready) @(negedge clk);
    cmd_type = T_IOW; cmd_addr = 16'h7F00; cmd_data = 8'hC7; cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_b = 1'b0;
    repeat (3) @(negedge clk);
    check(iorq_b == 1'b0 && wr_b == 1'b0, "io_tw_active", int'({iorq_b, wr_b}), 0);
    #2 reset_b = 1'b0;
    #1;
    check({mreq_b, iorq_b, rd_b, wr_b, ramrd_b} == 5'h1f, "async_reset_strobes",
          int'({mreq_b, iorq_b, rd_b, wr_b, ramrd_b}), 'h1f);
    check(bank_shadow == 6'h0 && adr == 16'h0 && !dout_oe, "async_reset_state",
          int'({bank_shadow, dout_oe}), 0);
    check(!cmd_ready && !rsp_valid, "async_reset_handshake", int'({cmd_ready, rsp_valid}), 0);
    exp_shadow = 6'h0;
    wait_b = 1'b1;
    @(negedge clk);
    #2 reset_b = 1'b1;
    #1 check(cmd_ready == 1'b0, "ready_before_rise2", int'(cmd_ready), 0);
    @(posedge clk);
    #1 check(cmd_ready == 1'b1, "ready_after_rise2", int'(cmd_ready), 1);
    @(negedge clk);

    run_cmd(T_MRD, 16'h0100, 8'h00, 1, 8'h3E);
    run_cmd(T_IOW, 16'h7F00, 8'hC9, 2, 8'h00);

    repeat (3) @(negedge clk);
    check(exp_q.size() == 0, "rsp_queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/cpc_bus_master.md
CPC_BUS_MASTER -- requirements
Module: cpc_bus_master

Interface
REQ-001 The block SHALL have port clk, input, 1, bus clock; one clk period = one Z80 T-state.
REQ-002 The block SHALL have port reset_b, input, 1; reset is reset_b, asynchronous, active-low.
REQ-003 The block SHALL have port cmd_valid, input, 1, command offered.
REQ-004 The block SHALL have port cmd_ready, output, 1, command accepted when cmd_valid & cmd_ready at clk rise.
REQ-005 The block SHALL have port cmd_type, input, 2: 00 mem read, 01 mem write, 10 I/O write, 11 reserved.
REQ-006 The block SHALL have ports cmd_addr (input, 16) and cmd_data (input, 8), the command address and write data.
REQ-007 The block SHALL have ports rsp_valid (output, 1), rsp_data (output, 8) and rsp_err (output, 1), the read/abort response.
REQ-008 The block SHALL have ports adr (output, 16), dout (output, 8), dout_oe (output, 1) and din (input, 8), the Z80-side address/data.
REQ-009 The block SHALL have ports mreq_b, iorq_b, rd_b, wr_b and ramrd_b (output, 1 each), active-low strobes.
REQ-010 The block SHALL have port wait_b, input, 1, active-low wait request.
REQ-011 The block SHALL have port bank_shadow, output, 6, mirror of the last bank-select value written.

Function
REQ-012 The FSM SHALL have states IDLE, T1, T2, TW, T3; cmd_ready is 1 only in IDLE.
REQ-013 On accept, the block SHALL latch the command and enter T1 next cycle; type 11 is accepted and then dropped, with a 1-cycle rsp_valid and rsp_err=1.
REQ-014 In T1, adr SHALL be the latched address and all strobes high; for writes, dout is the data and dout_oe=1 from T1 through T3.
REQ-015 For mem read, mreq_b, rd_b and ramrd_b SHALL be low in T2, TW and T3.
REQ-016 For mem write, mreq_b SHALL be low in T2, TW and T3, and wr_b low in TW and T3 only.
REQ-017 For I/O write, iorq_b and wr_b SHALL be low in T2, TW and T3.
REQ-018 wait_b SHALL be sampled at the end of T2 and of each TW: 0 -> TW, 1 -> T3.
REQ-019 T3 SHALL always be followed by IDLE, with all strobes high, adr held and dout_oe=0; the minimum command-to-command spacing is one IDLE cycle.
REQ-020 For mem read, din SHALL be captured at the end of T3, with rsp_valid=1 and rsp_data=din for exactly the first IDLE cycle.
REQ-021 Mem read latency SHALL be: accept at cycle n, rsp_valid at n+4 with no waits, plus 1 per TW.
REQ-022 An 8-bit wait counter SHALL clear on entry to T2 and increment per TW cycle; when it reaches 255, the cycle aborts to IDLE, with rsp_valid=1 and rsp_err=1 for 1 cycle.
REQ-023 An aborted cycle SHALL NOT update bank_shadow.
REQ-024 On completion of an I/O write (leaving T3) with adr[15]=0 and data[7:6]=11, bank_shadow SHALL load data[5:0].
REQ-025 Any other I/O write or mem access SHALL leave bank_shadow unchanged.
REQ-026 cmd inputs SHALL be ignored outside IDLE.

Reset
REQ-027 Asserting reset_b low SHALL immediately force FSM=IDLE, strobes high, adr=0, dout=0, dout_oe=0, cmd_ready=0, rsp_valid=0, rsp_err=0, rsp_data=0, bank_shadow=0 and wait counter=0, including mid-cycle.
REQ-028 cmd_ready SHALL go high on the first clk rise after reset_b deasserts.

Configuration
REQ-029 With macro CPC_IO_AUTOWAIT_EN defined, an I/O write SHALL insert one mandatory TW after T2, independent of wait_b, before wait_b sampling; this matches the Z80 automatic I/O wait.
REQ-030 Without CPC_IO_AUTOWAIT_EN, I/O cycles SHALL follow REQ-018 exactly, as memory cycles do.

Structure
REQ-031 Shared package cpc_bus_pkg SHALL hold: the cmd_type encodings, the FSM state encoding, the bank-select match constants (adr[15]=0, data[7:6]=11) and the wait limit of 255.
REQ-032 The wait counter plus abort compare SHALL be a sub-module named cpc_wait_timer; everything else is in cpc_bus_master.

Verification
REQ-033 Bench SHALL cover: I/O write adr=7F00, data=C2, wait_b=1 -> iorq_b/wr_b low for 2 cycles (3 with CPC_IO_AUTOWAIT_EN), bank_shadow=02.
REQ-034 Bench SHALL cover: I/O write adr=7F00, data=7F -> no shadow change; I/O write adr=FF00, data=C5 -> no shadow change.
REQ-035 Bench SHALL cover: mem read adr=4000, din=A5, wait_b=1 -> rsp_valid at accept+4, rsp_data=A5, ramrd_b low for 2 cycles.
REQ-036 Bench SHALL cover: mem write adr=C000, data=3C, wait_b low for 3 samples -> 3 TW, wr_b low for 4 cycles, no rsp_valid.
REQ-037 Bench SHALL cover: mem read with wait_b stuck low -> abort after 255 TW, rsp_err=1, bank_shadow unchanged.
REQ-038 Bench SHALL cover: reset_b pulsed low during TW of an I/O write data=C7 -> strobes high at once, bank_shadow=00, cmd_ready=1 on the first clk rise after release.
